inst_queue: RTL and testbench

- Dual-write, dual-read instruction buffer between the fetch stage and the issue stage.
- Fetch pushes up to two {pc, inst} entries per cycle.
- Issue sees the two oldest entries combinationally (first-word fall-through) and pops 0, 1 or 2 per cycle.
- Decouples fetch bandwidth from issue dual/single decisions. Supports a whole-queue flush on branch redirect or exception.

---
 rtl/idu_pkg.sv | 16 +
 rtl/fifo_mem_2w2r.sv | 38 +++
 rtl/inst_queue.sv | 111 +++++++++++
 tb/tb_inst_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// ============================================================================
// idu_pkg : shared instruction-decode constants and entry field positions
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package idu_pkg;
    localparam int IQ_DEPTH   = 16;
    localparam int IQ_ENTRY_W = 64;
    localparam int PC_HI      = 63;
    localparam int PC_LO      = 32;
    localparam int INST_HI    = 31;
    localparam int INST_LO    = 0;
endpackage

`default_nettype wire

// File: rtl/fifo_mem_2w2r.sv
// ============================================================================
// fifo_mem_2w2r : DEPTH x DATA_W register array, two write / two async reads
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_mem_2w2r #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we_a,
    input  logic [AW-1:0]     i_waddr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic              i_we_b,
    input  logic [AW-1:0]     i_waddr_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Port b is written last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
        if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// inst_queue : dual-push / dual-pop first-word-fall-through instruction buffer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module inst_queue
    import idu_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int DATA_W = IQ_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     w_ena_1,
    input  logic [DATA_W-1:0]        w_data_1,
    input  logic                     w_ena_2,
    input  logic [DATA_W-1:0]        w_data_2,
    output logic                     fifo_full,
    output logic [DATA_W-1:0]        fifo_r_data_1,
    output logic                     fifo_r_data_1_ok,
    output logic [DATA_W-1:0]        fifo_r_data_2,
    output logic                     fifo_r_data_2_ok,
    input  logic                     p_data_1,
    input  logic                     p_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_ok_1;
    logic              w_ok_2;
    logic              w_full;
    logic              w_pop_1;
    logic              w_pop_2;
    logic              w_push_1;
    logic              w_push_2;
    logic [1:0]        w_npop;
    logic [1:0]        w_npush;
    logic [AW-1:0]     w_head_nxt1;
    logic [AW-1:0]     w_waddr_b;
    logic [DATA_W-1:0] w_rd_1;
    logic [DATA_W-1:0] w_rd_2;

    assign w_ok_1  = (r_count >= CW'(1));
    assign w_ok_2  = (r_count >= CW'(2));
    assign w_full  = (r_count > CW'(DEPTH - 2));

    // The second pop only counts when it rides along with the first.
    assign w_pop_1 = p_data_1 & w_ok_1;
    assign w_pop_2 = p_data_1 & p_data_2 & w_ok_2;
    assign w_npop  = {1'b0, w_pop_1} + {1'b0, w_pop_2};

    assign w_push_1 = w_ena_1 & ~w_full;
    assign w_push_2 = w_ena_2 & ~w_full;
    assign w_npush  = {1'b0, w_push_1} + {1'b0, w_push_2};

    assign w_head_nxt1 = r_head + AW'(1);
    // A lone younger entry is compacted into the tail slot.
    assign w_waddr_b   = w_push_1 ? (r_tail + AW'(1)) : r_tail;

    fifo_mem_2w2r #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .i_we_a    (w_push_1 & ~flush),
        .i_waddr_a (r_tail),
        .i_wdata_a (w_data_1),
        .i_we_b    (w_push_2 & ~flush),
        .i_waddr_b (w_waddr_b),
        .i_wdata_b (w_data_2),
        .i_raddr_a (r_head),
        .o_rdata_a (w_rd_1),
        .i_raddr_b (w_head_nxt1),
        .o_rdata_b (w_rd_2)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_npop);
            r_tail  <= r_tail + AW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
        end
    end

    assign fifo_full        = w_full;
    assign fifo_r_data_1_ok = w_ok_1;
    assign fifo_r_data_2_ok = w_ok_2;
    assign fifo_r_data_1    = w_ok_1 ? w_rd_1 : '0;
    assign fifo_r_data_2    = w_ok_2 ? w_rd_2 : '0;
    assign count            = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// tb_inst_queue : scoreboard bench for inst_queue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;

    localparam int DEPTH = 16;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        w_ena_1;
    logic [63:0] w_data_1;
    logic        w_ena_2;
    logic [63:0] w_data_2;
    logic        fifo_full;
    logic [63:0] fifo_r_data_1;
    logic        fifo_r_data_1_ok;
    logic [63:0] fifo_r_data_2;
    logic        fifo_r_data_2_ok;
    logic        p_data_1;
    logic        p_data_2;
    logic [4:0]  count;

    inst_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .flush            (flush),
        .w_ena_1          (w_ena_1),
        .w_data_1         (w_data_1),
        .w_ena_2          (w_ena_2),
        .w_data_2         (w_data_2),
        .fifo_full        (fifo_full),
        .fifo_r_data_1    (fifo_r_data_1),
        .fifo_r_data_1_ok (fifo_r_data_1_ok),
        .fifo_r_data_2    (fifo_r_data_2),
        .fifo_r_data_2_ok (fifo_r_data_2_ok),
        .p_data_1         (p_data_1),
        .p_data_2         (p_data_2),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb_q[$];
    int          seq    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mk(input int k);
        logic [31:0] pc;
        logic [31:0] ins;
        pc  = 32'hBFC0_0100 + 32'(k) * 32'd4;
        ins = 32'h2400_0000 + 32'(k);
        return {pc, ins};
    endfunction

    // Compare the visible outputs with the scoreboard, drive one cycle of
    // stimulus, then update the scoreboard with what the queue must accept.
    task automatic step(input logic e1, input logic [63:0] d1,
                        input logic e2, input logic [63:0] d2,
                        input logic pp1, input logic pp2, input logic fl);
        int          sz;
        logic        full_m;
        logic [63:0] got;
        sz     = sb_q.size();
        full_m = (sz > DEPTH - 2);
        chk("count",   64'(count), 64'(sz));
        chk("cnt_max", 64'(count <= 5'(DEPTH)), 64'd1);
        chk("ok1",     64'(fifo_r_data_1_ok), 64'(sz >= 1));
        chk("ok2",     64'(fifo_r_data_2_ok), 64'(sz >= 2));
        chk("full",    64'(fifo_full), 64'(full_m));
        chk("data1",   fifo_r_data_1, (sz >= 1) ? sb_q[0] : 64'd0);
        chk("data2",   fifo_r_data_2, (sz >= 2) ? sb_q[1] : 64'd0);

        w_ena_1 = e1; w_data_1 = d1; w_ena_2 = e2; w_data_2 = d2;
        p_data_1 = pp1; p_data_2 = pp2; flush = fl;

        if (fl) begin
            sb_q.delete();
        end else begin
            if (pp1 && sz >= 1) begin
                got = sb_q.pop_front();
                chk("pop1", fifo_r_data_1, got);
                if (pp2 && sz >= 2) begin
                    got = sb_q.pop_front();
                    chk("pop2", fifo_r_data_2, got);
                end
            end
            if (!full_m) begin
                if (e1) sb_q.push_back(d1);
                if (e2) sb_q.push_back(d2);
            end
        end
        @(posedge clk);
        #1;
        w_ena_1 = 1'b0; w_ena_2 = 1'b0; p_data_1 = 1'b0; p_data_2 = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push2();
        step(1'b1, mk(seq), 1'b1, mk(seq + 1), 1'b0, 1'b0, 1'b0);
        seq += 2;
    endtask

    task automatic push1();
        step(1'b1, mk(seq), 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        seq += 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++)
            step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [63:0] second;
        resetn = 1'b0; flush = 1'b0;
        w_ena_1 = 1'b0; w_data_1 = '0; w_ena_2 = 1'b0; w_data_2 = '0;
        p_data_1 = 1'b0; p_data_2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ok1",   64'(fifo_r_data_1_ok), 64'd0);
        chk("rst_full",  64'(fifo_full), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        idle();

        // Dual push then dual pop
        step(1'b1, {32'hBFC0_0000, 32'h2401_0001}, 1'b1, {32'hBFC0_0004, 32'h2402_0002},
             1'b0, 1'b0, 1'b0);
        chk("dp_r1", fifo_r_data_1, {32'hBFC0_0000, 32'h2401_0001});
        chk("dp_r2", fifo_r_data_2, {32'hBFC0_0004, 32'h2402_0002});
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        idle();

        // Lone younger write compacts into the head slot; lone p_data_2 ignored
        step(1'b0, 64'd0, 1'b1, {32'hBFC0_0008, 32'h2403_0003}, 1'b0, 1'b0, 1'b0);
        chk("w2_r1", fifo_r_data_1, {32'hBFC0_0008, 32'h2403_0003});
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("p2_only", 64'(count), 64'd1);
        drain();

        // Fill to 15, confirm a further pair is dropped
        push1();
        while (sb_q.size() < 15) push2();
        chk("full_at15", 64'(fifo_full), 64'd1);
        push2();
        chk("full_drop", 64'(count), 64'd15);

        // Pop one per cycle while pushing pairs across the wrap point
        for (int i = 0; i < 40; i++) begin
            step(1'b1, mk(seq), 1'b1, mk(seq + 1), 1'b1, 1'b0, 1'b0);
            seq += 2;
        end
        drain();

        // Push 2 / pop 1 at count 3
        push2(); push1();
        second = sb_q[1];
        step(1'b1, mk(seq), 1'b1, mk(seq + 1), 1'b1, 1'b0, 1'b0);
        seq += 2;
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_head",  fifo_r_data_1, second);
        drain();

        // Flush at count 9 with concurrent push 2 / pop 2
        push1();
        while (sb_q.size() < 9) push2();
        chk("pre_flush", 64'(count), 64'd9);
        step(1'b1, mk(seq), 1'b1, mk(seq + 1), 1'b1, 1'b1, 1'b1);
        seq += 2;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_ok1",   64'(fifo_r_data_1_ok), 64'd0);
        push2();
        chk("fl_head0", 64'(dut.r_head), 64'd0);
        idle();
        drain();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
